// File: rtl/ucsbece154a_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and operand-signedness helpers.
package ucsbece154a_muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        MULDIV_MUL    = 3'd0,
        MULDIV_MULH   = 3'd1,
        MULDIV_MULHSU = 3'd2,
        MULDIV_MULHU  = 3'd3,
        MULDIV_DIV    = 3'd4,
        MULDIV_DIVU   = 3'd5,
        MULDIV_REM    = 3'd6,
        MULDIV_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    // rs1 is treated as two's complement for these ops
    function automatic logic op_a_signed(input logic [2:0] op);
        logic s;
        case (op)
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM: s = 1'b1;
            default:                                           s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic op_b_signed(input logic [2:0] op);
        logic s;
        case (op)
            MULDIV_MULH, MULDIV_DIV, MULDIV_REM: s = 1'b1;
            default:                             s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ucsbece154a_muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface ucsbece154a_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic             abort_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [4:0]       rd_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [4:0]       rd_o;
    logic             we_o;

    modport master (
        output start_i, abort_i, op_i, a_i, b_i, rd_i,
        input  busy_o, done_o, result_o, rd_o, we_o
    );

    modport slave (
        input  start_i, abort_i, op_i, a_i, b_i, rd_i,
        output busy_o, done_o, result_o, rd_o, we_o
    );
endinterface

// File: rtl/ucsbece154a_muldiv.sv
// Iterative RV32M multiply/divide unit. Operands are converted to magnitudes
// on acceptance, a shared 2*WIDTH accumulator runs WIDTH shift-add or
// restoring-divide steps, and a single fix-up cycle restores sign and picks
// the requested half. Latency is fixed for every op and operand value.
module ucsbece154a_muldiv
    import ucsbece154a_muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input logic                  clk,
    input logic                  reset,
    ucsbece154a_muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    muldiv_state_e      state_r, state_s;
    muldiv_op_e         op_r;
    logic [2*WIDTH-1:0] acc_r, step_s, prod_s;
    logic [WIDTH-1:0]   opb_r, abs_a_s, abs_b_s, quot_s, rem_s, fix_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [4:0]         rd_r, rd_out_r;
    logic               neg_r, rem_neg_r, div0_r, ovf_r;
    logic               a_neg_s, b_neg_s, div0_s, ovf_s, start_ok_s;
    logic [WIDTH:0]     mul_sum_s, trial_s, diff_s;
    logic               q_bit_s;
    logic [WIDTH-1:0]   result_r;
    logic               busy_r, done_r, we_r;

    assign start_ok_s = (state_r == ST_IDLE) && bus.start_i && !bus.abort_i;

    // Operand magnitudes and special-case flags captured on acceptance
    always_comb begin
        a_neg_s = op_a_signed(bus.op_i) & bus.a_i[WIDTH-1];
        b_neg_s = op_b_signed(bus.op_i) & bus.b_i[WIDTH-1];
        abs_a_s = a_neg_s ? neg_w(bus.a_i) : bus.a_i;
        abs_b_s = b_neg_s ? neg_w(bus.b_i) : bus.b_i;
        div0_s  = bus.op_i[2] && (bus.b_i == {WIDTH{1'b0}});
        ovf_s   = ((bus.op_i == MULDIV_DIV) || (bus.op_i == MULDIV_REM)) &&
                  (bus.a_i == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (bus.b_i == {WIDTH{1'b1}});
    end

    // Next-state logic; abort always wins and DONE lasts a single cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_s = ST_CALC;
                else            state_s = ST_IDLE;
            end
            ST_CALC: begin
                if (bus.abort_i)            state_s = ST_IDLE;
                else if (cnt_r == CNT_LAST) state_s = ST_FIX;
                else                        state_s = ST_CALC;
            end
            ST_FIX: begin
                if (bus.abort_i) state_s = ST_IDLE;
                else             state_s = ST_DONE;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) iteration on the accumulator
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                    (acc_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
        trial_s   = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s    = trial_s - {1'b0, opb_r};
        q_bit_s   = ~diff_s[WIDTH];
        if (op_r[2]) begin
            step_s = {(q_bit_s ? diff_s[WIDTH-1:0] : trial_s[WIDTH-1:0]),
                      acc_r[WIDTH-2:0], q_bit_s};
        end else begin
            step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction, special cases and half select applied in FIX
    always_comb begin
        prod_s = neg_r ? neg_2w(acc_r) : acc_r;
        if (div0_r)     quot_s = {WIDTH{1'b1}};
        else if (ovf_r) quot_s = {1'b1, {(WIDTH-1){1'b0}}};
        else if (neg_r) quot_s = neg_w(acc_r[WIDTH-1:0]);
        else            quot_s = acc_r[WIDTH-1:0];
        if (ovf_r)          rem_s = {WIDTH{1'b0}};
        else if (rem_neg_r) rem_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
        else                rem_s = acc_r[2*WIDTH-1:WIDTH];
        case (op_r)
            MULDIV_MUL:                              fix_s = prod_s[WIDTH-1:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: fix_s = prod_s[2*WIDTH-1:WIDTH];
            MULDIV_DIV, MULDIV_DIVU:                 fix_s = quot_s;
            MULDIV_REM, MULDIV_REMU:                 fix_s = rem_s;
            default:                                 fix_s = {WIDTH{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Operand latch on acceptance and one datapath iteration per CALC edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r     <= {(2*WIDTH){1'b0}};
            opb_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= MULDIV_MUL;
            rd_r      <= 5'd0;
            neg_r     <= 1'b0;
            rem_neg_r <= 1'b0;
            div0_r    <= 1'b0;
            ovf_r     <= 1'b0;
        end else if (start_ok_s) begin
            acc_r     <= {{WIDTH{1'b0}}, abs_a_s};
            opb_r     <= abs_b_s;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= muldiv_op_e'(bus.op_i);
            rd_r      <= bus.rd_i;
            neg_r     <= a_neg_s ^ b_neg_s;
            rem_neg_r <= a_neg_s;
            div0_r    <= div0_s;
            ovf_r     <= ovf_s;
        end else if (state_r == ST_CALC) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Registered status flags and result/destination hold registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            we_r     <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            rd_out_r <= 5'd0;
        end else begin
            busy_r <= (state_s == ST_CALC) || (state_s == ST_FIX);
            done_r <= (state_s == ST_DONE);
            we_r   <= (state_s == ST_DONE) && (rd_r != 5'd0);
            if ((state_r == ST_FIX) && (state_s == ST_DONE)) begin
                result_r <= fix_s;
                rd_out_r <= rd_r;
            end
        end
    end

    assign bus.busy_o   = busy_r;
    assign bus.done_o   = done_r;
    assign bus.we_o     = we_r;
    assign bus.result_o = result_r;
    assign bus.rd_o     = rd_out_r;

endmodule

// File: tb/tb_ucsbece154a_muldiv.sv
// Bench for the iterative multiply/divide unit: a vector table run through a
// scoreboard queue, plus hand sequences for busy/abort/reset corner cases.
module tb_ucsbece154a_muldiv;

    logic clk;
    logic reset;

    ucsbece154a_muldiv_if #(.WIDTH(32)) bus ();

    ucsbece154a_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    localparam int NV = 18;
    vec_t vecs [0:NV-1];
    exp_t exp_q [$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bus.done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result", bus.result_o, e.res);
                chk("rd", {27'd0, bus.rd_o}, {27'd0, e.rd});
                chk("we", {31'd0, bus.we_o}, {31'd0, e.we});
            end
        end
    end

    // Issue one op, optionally poke a stray start at a given cycle, check latency
    task automatic run_op(input vec_t v, input int poke_at);
        exp_t e;
        int   lat;
        lat   = -1;
        e.res = v.exp;
        e.rd  = v.rd;
        e.we  = (v.rd != 5'd0);
        exp_q.push_back(e);
        bus.op_i    = v.op;
        bus.a_i     = v.a;
        bus.b_i     = v.b;
        bus.rd_i    = v.rd;
        bus.start_i = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (cyc == 1) chk("busy_after_start", {31'd0, bus.busy_o}, 32'd1);
            if (cyc == poke_at) begin
                bus.start_i = 1'b1;
                bus.op_i    = 3'd0;
                bus.a_i     = 32'd5;
                bus.b_i     = 32'd5;
                bus.rd_i    = 5'd9;
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.done_o === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        chk("latency", lat, 32'd34);
        if (lat < 0) exp_q.delete();
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("idle_after_done", {31'd0, bus.busy_o}, 32'd0);
    endtask

    initial begin
        vec_t v;
        reset       = 1'b1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.op_i    = 3'd0;
        bus.a_i     = 32'd0;
        bus.b_i     = 32'd0;
        bus.rd_i    = 5'd0;

        vecs[0]  = '{op: 3'd0, a: 32'd7,          b: 32'hFFFF_FFFD, rd: 5'd5,  exp: 32'hFFFF_FFEB};
        vecs[1]  = '{op: 3'd1, a: 32'h8000_0000,  b: 32'h8000_0000, rd: 5'd6,  exp: 32'h4000_0000};
        vecs[2]  = '{op: 3'd3, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, rd: 5'd7,  exp: 32'hFFFF_FFFE};
        vecs[3]  = '{op: 3'd2, a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF, rd: 5'd8,  exp: 32'hFFFF_FFFF};
        vecs[4]  = '{op: 3'd4, a: 32'hFFFF_FFF9,  b: 32'd2,         rd: 5'd9,  exp: 32'hFFFF_FFFD};
        vecs[5]  = '{op: 3'd6, a: 32'hFFFF_FFF9,  b: 32'd2,         rd: 5'd10, exp: 32'hFFFF_FFFF};
        vecs[6]  = '{op: 3'd5, a: 32'd100,        b: 32'd7,         rd: 5'd11, exp: 32'd14};
        vecs[7]  = '{op: 3'd7, a: 32'd100,        b: 32'd7,         rd: 5'd12, exp: 32'd2};
        vecs[8]  = '{op: 3'd4, a: 32'd123,        b: 32'd0,         rd: 5'd13, exp: 32'hFFFF_FFFF};
        vecs[9]  = '{op: 3'd6, a: 32'd123,        b: 32'd0,         rd: 5'd14, exp: 32'd123};
        vecs[10] = '{op: 3'd5, a: 32'd123,        b: 32'd0,         rd: 5'd15, exp: 32'hFFFF_FFFF};
        vecs[11] = '{op: 3'd7, a: 32'd123,        b: 32'd0,         rd: 5'd16, exp: 32'd123};
        vecs[12] = '{op: 3'd4, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, rd: 5'd17, exp: 32'h8000_0000};
        vecs[13] = '{op: 3'd6, a: 32'h8000_0000,  b: 32'hFFFF_FFFF, rd: 5'd18, exp: 32'd0};
        vecs[14] = '{op: 3'd0, a: 32'd12345,      b: 32'd678,       rd: 5'd0,  exp: 32'd8369910};
        vecs[15] = '{op: 3'd1, a: 32'hFFFF_FFFF,  b: 32'd2,         rd: 5'd19, exp: 32'hFFFF_FFFF};
        vecs[16] = '{op: 3'd4, a: 32'd7,          b: 32'hFFFF_FFFE, rd: 5'd20, exp: 32'hFFFF_FFFD};
        vecs[17] = '{op: 3'd6, a: 32'd7,          b: 32'hFFFF_FFFE, rd: 5'd21, exp: 32'd1};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy",   {31'd0, bus.busy_o}, 32'd0);
        chk("rst_done",   {31'd0, bus.done_o}, 32'd0);
        chk("rst_we",     {31'd0, bus.we_o},   32'd0);
        chk("rst_result", bus.result_o,        32'd0);
        chk("rst_rd",     {27'd0, bus.rd_o},   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // table-driven operations
        for (int i = 0; i < NV; i++) run_op(vecs[i], 0);

        // stray start while busy must not disturb the in-flight op
        v = '{op: 3'd5, a: 32'd1000, b: 32'd10, rd: 5'd22, exp: 32'd100};
        run_op(v, 5);

        // start presented during the DONE cycle must be ignored
        v = '{op: 3'd3, a: 32'h0001_0000, b: 32'h0001_0000, rd: 5'd23, exp: 32'd1};
        run_op(v, 34);
        repeat (40) @(negedge clk);

        // abort and start together in IDLE: nothing accepted
        bus.op_i = 3'd0; bus.a_i = 32'd2; bus.b_i = 32'd2; bus.rd_i = 5'd3;
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("abort_start_idle", {31'd0, bus.busy_o}, 32'd0);
        repeat (40) @(negedge clk);

        // abort at CALC cycle 10, restart one cycle later
        bus.op_i = 3'd0; bus.a_i = 32'd3; bus.b_i = 32'd4; bus.rd_i = 5'd7;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_idle", {31'd0, bus.busy_o}, 32'd0);
        chk("abort_keeps_result", bus.result_o, 32'd1);
        v = '{op: 3'd0, a: 32'd6, b: 32'd7, rd: 5'd4, exp: 32'd42};
        run_op(v, 0);

        // reset mid-CALC clears outputs asynchronously
        bus.op_i = 3'd4; bus.a_i = 32'd99; bus.b_i = 32'd3; bus.rd_i = 5'd2;
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy",   {31'd0, bus.busy_o}, 32'd0);
        chk("midrst_done",   {31'd0, bus.done_o}, 32'd0);
        chk("midrst_we",     {31'd0, bus.we_o},   32'd0);
        chk("midrst_result", bus.result_o,        32'd0);
        chk("midrst_rd",     {27'd0, bus.rd_o},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
